// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode encodings and flag bit positions
// Contents: ALU_ADD..ALU_MOV opcode localparams and FLAG_N/Z/C/V indices into ALUFlags.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_BIC = 3'b101;
    localparam logic [2:0] ALU_MVN = 3'b110;
    localparam logic [2:0] ALU_MOV = 3'b111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_adder.sv
// rtl/alu_adder.sv - WIDTH+1 bit adder with carry-in and carry-out
// Ports: x, y (addends), cin (carry-in), sum (WIDTH-bit sum), cout (carry out of the MSB).
module alu_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - ARM-style ALU with combinational result/flags and a registered copy
// Ports: clk, reset (sync, active-high); a, b operands; ALUControl opcode;
//        Result/ALUFlags combinational outputs ({N,Z,C,V});
//        Result_q/ALUFlags_q the same values captured on each rising clk edge.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic [WIDTH-1:0] Result_q,
    output logic [3:0]       ALUFlags_q
);

    logic             is_sub;
    logic             is_arith;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // SUB reuses the adder as a + ~b + 1, so carry-out means "no borrow".
    assign is_sub   = (ALUControl == ALU_SUB);
    assign is_arith = (ALUControl == ALU_ADD) || is_sub;
    assign b_eff    = is_sub ? ~b : b;

    alu_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .x    (a),
        .y    (b_eff),
        .cin  (is_sub),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD, ALU_SUB: Result = sum;
            ALU_AND:          Result = a & b;
            ALU_ORR:          Result = a | b;
            ALU_EOR:          Result = a ^ b;
            ALU_BIC:          Result = a & ~b;
            ALU_MVN:          Result = ~b;
            ALU_MOV:          Result = b;
            default:          Result = '0;
        endcase
    end

    always_comb begin
        ALUFlags         = '0;
        ALUFlags[FLAG_N] = Result[WIDTH-1];
        ALUFlags[FLAG_Z] = (Result == '0);
        ALUFlags[FLAG_C] = is_arith & cout;
        // Overflow on the adder inputs: for SUB, b_eff is ~b, so "signs of a and
        // b_eff equal" is the same as "signs of a and b differ".
        ALUFlags[FLAG_V] = is_arith & (a[WIDTH-1] == b_eff[WIDTH-1])
                                    & (sum[WIDTH-1] != a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Result_q   <= '0;
            ALUFlags_q <= '0;
        end else begin
            Result_q   <= Result;
            ALUFlags_q <= ALUFlags;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu with a registered-path scoreboard
module tb_alu;
    import alu_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ALUControl;
    logic [31:0] Result;
    logic [3:0]  ALUFlags;
    logic [31:0] Result_q;
    logic [3:0]  ALUFlags_q;

    int n_vec = 0;
    int n_bad = 0;
    logic [35:0] sb[$];

    always #5 clk = ~clk;

    alu #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .ALUControl (ALUControl),
        .Result     (Result),
        .ALUFlags   (ALUFlags),
        .Result_q   (Result_q),
        .ALUFlags_q (ALUFlags_q)
    );

    // Reference model: {flags, result}; V derived from signed 64-bit arithmetic.
    function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        v;
        longint      sx;
        longint      sy;
        longint      ss;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        case (op)
            3'd0: begin
                w  = {1'b0, x} + {1'b0, y};
                r  = w[31:0];
                c  = w[32];
                ss = sx + sy;
                v  = (ss != longint'($signed(r)));
            end
            3'd1: begin
                r  = x - y;
                c  = (x >= y);
                ss = sx - sy;
                v  = (ss != longint'($signed(r)));
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = x & ~y;
            3'd6: r = ~y;
            default: r = y;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    task automatic drive(input logic rst, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        reset      = rst;
        ALUControl = op;
        a          = x;
        b          = y;
        #1;
    endtask

    task automatic test_reset();
        logic [35:0] got;
        logic [35:0] exp;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
            n_vec++;
            if ({ALUFlags, Result} !== {4'b0110, 32'h0}) begin
                n_bad++;
                $display("FAIL reset_comb[%0d]: got %h/%b want 00000000/0110", i, Result, ALUFlags);
            end
            sb.push_back(36'h0);
            @(posedge clk);
            #1;
            got = {ALUFlags_q, Result_q};
            exp = sb.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL reset_reg[%0d]: got %h want %h", i, got, exp);
            end
        end
        drive(1'b0, ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        sb.push_back({4'b0110, 32'h0});
        @(posedge clk);
        #1;
        got = {ALUFlags_q, Result_q};
        exp = sb.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL reset_release: got %h want %h", got, exp);
        end
    endtask

    task automatic test_add();
        vec_t t[4];
        logic [35:0] got;
        logic [35:0] exp;
        t[0] = '{ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
        t[1] = '{ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
        t[2] = '{ALU_ADD, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100};
        t[3] = '{ALU_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0111};
        foreach (t[i]) begin
            drive(1'b0, t[i].op, t[i].x, t[i].y);
            n_vec++;
            if ({ALUFlags, Result} !== {t[i].f, t[i].r}) begin
                n_bad++;
                $display("FAIL add[%0d]: got %h/%b want %h/%b", i, Result, ALUFlags, t[i].r, t[i].f);
            end
            sb.push_back({t[i].f, t[i].r});
            @(posedge clk);
            #1;
            got = {ALUFlags_q, Result_q};
            exp = sb.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL add_reg[%0d]: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_sub();
        vec_t t[5];
        logic [35:0] got;
        logic [35:0] exp;
        t[0] = '{ALU_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110};
        t[1] = '{ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000};
        t[2] = '{ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011};
        t[3] = '{ALU_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1001};
        t[4] = '{ALU_SUB, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 4'b0010};
        foreach (t[i]) begin
            drive(1'b0, t[i].op, t[i].x, t[i].y);
            n_vec++;
            if ({ALUFlags, Result} !== {t[i].f, t[i].r}) begin
                n_bad++;
                $display("FAIL sub[%0d]: got %h/%b want %h/%b", i, Result, ALUFlags, t[i].r, t[i].f);
            end
            sb.push_back({t[i].f, t[i].r});
            @(posedge clk);
            #1;
            got = {ALUFlags_q, Result_q};
            exp = sb.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL sub_reg[%0d]: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_logic();
        vec_t t[6];
        logic [35:0] got;
        logic [35:0] exp;
        t[0] = '{ALU_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 4'b0100};
        t[1] = '{ALU_ORR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 4'b1000};
        t[2] = '{ALU_EOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 4'b1000};
        t[3] = '{ALU_BIC, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'b1000};
        t[4] = '{ALU_MVN, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'b1000};
        t[5] = '{ALU_MOV, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 4'b0000};
        foreach (t[i]) begin
            drive(1'b0, t[i].op, t[i].x, t[i].y);
            n_vec++;
            if ({ALUFlags, Result} !== {t[i].f, t[i].r}) begin
                n_bad++;
                $display("FAIL logic[%0d]: got %h/%b want %h/%b", i, Result, ALUFlags, t[i].r, t[i].f);
            end
            sb.push_back({t[i].f, t[i].r});
            @(posedge clk);
            #1;
            got = {ALUFlags_q, Result_q};
            exp = sb.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL logic_reg[%0d]: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] edge_vals[5];
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  op;
        logic [35:0] e;
        logic [35:0] got;
        logic [35:0] exp;
        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'h0000_0001;
        edge_vals[2] = 32'h7FFF_FFFF;
        edge_vals[3] = 32'h8000_0000;
        edge_vals[4] = 32'hFFFF_FFFF;
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            y  = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            e  = model(op, x, y);
            drive(1'b0, op, x, y);
            n_vec++;
            if ({ALUFlags, Result} !== e) begin
                n_bad++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got %h/%b want %h/%b",
                         i, op, x, y, Result, ALUFlags, e[31:0], e[35:32]);
            end
            sb.push_back(e);
            @(posedge clk);
            #1;
            got = {ALUFlags_q, Result_q};
            exp = sb.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL b2b_reg[%0d]: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [2:0]  ops[3];
        logic [31:0] xs[3];
        logic [31:0] ys[3];
        logic        rs[3];
        logic [35:0] e;
        logic [35:0] got;
        logic [35:0] exp;
        ops[0] = ALU_MOV; xs[0] = 32'h0; ys[0] = 32'h1234_5678; rs[0] = 1'b0;
        ops[1] = ALU_ORR; xs[1] = 32'h8000_0000; ys[1] = 32'h0000_00FF; rs[1] = 1'b1;
        ops[2] = ALU_EOR; xs[2] = 32'hA5A5_A5A5; ys[2] = 32'hFFFF_0000; rs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e = model(ops[i], xs[i], ys[i]);
            drive(rs[i], ops[i], xs[i], ys[i]);
            n_vec++;
            if ({ALUFlags, Result} !== e) begin
                n_bad++;
                $display("FAIL mid_comb[%0d]: got %h/%b want %h/%b", i, Result, ALUFlags, e[31:0], e[35:32]);
            end
            sb.push_back(rs[i] ? 36'h0 : e);
            @(posedge clk);
            #1;
            got = {ALUFlags_q, Result_q};
            exp = sb.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL mid_reg[%0d]: got %h want %h", i, got, exp);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        a          = '0;
        b          = '0;
        ALUControl = ALU_ADD;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 32, data-path width in bits; all requirements below use WIDTH=32.
REQ-002 clk  input  1  single clock; all registered state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 a  input  32  operand A.
REQ-005 b  input  32  operand B.
REQ-006 ALUControl  input  3  operation select.
REQ-007 Result  output  32  combinational result of the selected operation.
REQ-008 ALUFlags  output  4  combinational flags {N,Z,C,V}: bit3=N, bit2=Z, bit1=C, bit0=V.
REQ-009 Result_q  output  32  Result registered on clk.
REQ-010 ALUFlags_q  output  4  ALUFlags registered on clk.

Function
REQ-011 Result and ALUFlags SHALL be purely combinational in a, b and ALUControl, with zero-cycle latency and no dependence on clk or reset.
REQ-012 ALUControl encoding SHALL be: 000 ADD a+b; 001 SUB a-b; 010 AND a&b; 011 ORR a|b; 100 EOR a^b; 101 BIC a&~b; 110 MVN ~b; 111 MOV b.
REQ-013 ADD and SUB SHALL use one shared 33-bit adder; SUB is computed as a + ~b + 1.
REQ-014 Sums SHALL wrap modulo 2^32; the bit-32 carry-out is not part of Result.
REQ-015 N SHALL equal Result[31] for every operation.
REQ-016 Z SHALL be 1 if and only if Result == 0, for every operation.
REQ-017 C SHALL be the adder carry-out for ADD and SUB, so SUB gives C=1 when there is no borrow (a >= b unsigned), ARM convention.
REQ-018 C SHALL be 0 for operations 010-111.
REQ-019 V for ADD SHALL be (a[31]==b[31]) and (Result[31]!=a[31]).
REQ-020 V for SUB SHALL be (a[31]!=b[31]) and (Result[31]!=a[31]).
REQ-021 V SHALL be 0 for operations 010-111.
REQ-022 If any input contains X/Z, outputs are don't-care; every defined input combination SHALL produce fully defined outputs, with no latches.
REQ-023 On each rising clk edge with reset=0, Result_q and ALUFlags_q SHALL load the current Result and ALUFlags (one-cycle latency).

Reset
REQ-024 On a rising clk edge with reset=1, Result_q SHALL become 0x00000000 and ALUFlags_q SHALL become 4'b0000.
REQ-025 Reset SHALL take priority over capture.
REQ-026 Reset SHALL have no effect on the combinational Result and ALUFlags.
REQ-027 Asserting reset mid-stream SHALL discard the capture for that edge only; capture resumes on the first edge with reset=0.

Structure
REQ-028 A shared package alu_pkg SHALL hold the ALUControl opcode localparams (ALU_ADD..ALU_MOV) and the flag bit-index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
REQ-029 One sub-module, alu_adder (33-bit add with carry-in and carry-out), SHALL be instantiated once for ADD/SUB.
REQ-030 All logic operations and flag logic SHALL stay inline in alu.

Verification
REQ-031 ADD a=FFFFFFFF, b=00000001 -> Result=00000000, ALUFlags=0110.
REQ-032 ADD a=7FFFFFFF, b=00000001 -> Result=80000000, ALUFlags=1001.
REQ-033 SUB a=00000005, b=00000005 -> Result=00000000, ALUFlags=0110; then SUB a=00000000, b=00000001 -> Result=FFFFFFFF, ALUFlags=1000.
REQ-034 SUB a=80000000, b=00000001 -> Result=7FFFFFFF, ALUFlags=0011.
REQ-035 AND F0F0F0F0 & 0F0F0F0F -> 00000000, flags 0100; ORR -> FFFFFFFF, flags 1000; EOR -> FFFFFFFF, flags 1000; BIC -> F0F0F0F0, flags 1000; MVN b=0F0F0F0F -> F0F0F0F0, flags 1000; MOV b=0F0F0F0F -> 0F0F0F0F, flags 0000.
REQ-036 Registered path: with reset=1 for two edges, Result_q=0 and ALUFlags_q=0 even while ADD FFFFFFFF+1 is applied; after reset drops, the next edge gives Result_q=00000000 and ALUFlags_q=0110.
REQ-037 Registered path self-check: Result_q and ALUFlags_q SHALL always equal the combinational Result and ALUFlags sampled one edge earlier.
